// File: rtl/bf_fetch_if.sv
// Fetch-side bus of the BF sequencer: ROM address/data, instruction handshake
// toward the execution unit, and the status flags.
interface bf_fetch_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] rom_address;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] insn;
    logic                  insn_valid;
    logic                  insn_ready;
    logic                  cell_zero;
    logic                  halted;
    logic                  error;

    modport master (
        output rom_address, insn, insn_valid, halted, error,
        input  rom_data, insn_ready, cell_zero
    );

    modport slave (
        input  rom_address, insn, insn_valid, halted, error,
        output rom_data, insn_ready, cell_zero
    );
endinterface

// File: rtl/bf_fetch_sequencer.sv
// Program-counter sequencer for the BF instruction ROM; resolves loop brackets
// by scanning the ROM with a nesting-depth counter.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   RUN       | fetch/offer one instruction per cycle, evaluate brackets
//   SKIP_FWD  | scanning forward for the `]` matching a skipped `[`
//   SKIP_BACK | scanning backward for the `[` matching a taken `]`
//   HALT      | halt opcode reached, pc frozen until reset
//   ERROR     | unmatched bracket / depth overflow / pc overrun, frozen
module bf_fetch_sequencer #(
    parameter int                   DATA_WIDTH    = 4,
    parameter int                   ADDR_WIDTH    = 8,
    parameter int                   DEPTH_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] OP_LOOP_START = 4'h5,
    parameter logic [DATA_WIDTH-1:0] OP_LOOP_END   = 4'h6,
    parameter logic [DATA_WIDTH-1:0] OP_HALT       = 4'hF
) (
    input  logic         clk,
    input  logic         reset,
    bf_fetch_if.master   bus
);

    typedef enum logic [2:0] {RUN, SKIP_FWD, SKIP_BACK, HALT, ERROR} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  pc, pc_nxt;
    logic [DEPTH_WIDTH-1:0] depth, depth_nxt;
    logic                   is_open, is_close, is_halt;
    logic                   pc_last, pc_first, depth_full, depth_one;
    logic                   insn_valid;

    assign is_open    = (bus.rom_data == OP_LOOP_START);
    assign is_close   = (bus.rom_data == OP_LOOP_END);
    assign is_halt    = (bus.rom_data == OP_HALT);
    assign pc_last    = (pc == {ADDR_WIDTH{1'b1}});
    assign pc_first   = (pc == '0);
    assign depth_full = (depth == {DEPTH_WIDTH{1'b1}});
    assign depth_one  = (depth == DEPTH_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= '0;
            depth <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            depth <= depth_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        depth_nxt  = depth;
        insn_valid = 1'b0;
        case (state)
            RUN: begin
                if (is_halt) begin
                    state_nxt = HALT;
                end else if (is_open) begin
                    if (pc_last) begin
                        state_nxt = ERROR;
                    end else begin
                        pc_nxt = pc + ADDR_WIDTH'(1);
                        if (bus.cell_zero) begin
                            depth_nxt = DEPTH_WIDTH'(1);
                            state_nxt = SKIP_FWD;
                        end
                    end
                end else if (is_close) begin
                    if (bus.cell_zero) begin
                        if (pc_last) state_nxt = ERROR;
                        else         pc_nxt    = pc + ADDR_WIDTH'(1);
                    end else if (pc_first) begin
                        state_nxt = ERROR;
                    end else begin
                        depth_nxt = DEPTH_WIDTH'(1);
                        pc_nxt    = pc - ADDR_WIDTH'(1);
                        state_nxt = SKIP_BACK;
                    end
                end else begin
                    insn_valid = 1'b1;
                    if (bus.insn_ready) begin
                        if (pc_last) state_nxt = ERROR;
                        else         pc_nxt    = pc + ADDR_WIDTH'(1);
                    end
                end
            end
            // every forward-scan step advances pc, so the end of ROM is fatal
            SKIP_FWD: begin
                if (pc_last || (is_open && depth_full)) begin
                    state_nxt = ERROR;
                end else begin
                    pc_nxt = pc + ADDR_WIDTH'(1);
                    if (is_open) begin
                        depth_nxt = depth + DEPTH_WIDTH'(1);
                    end else if (is_close) begin
                        if (depth_one) state_nxt = RUN;
                        else           depth_nxt = depth - DEPTH_WIDTH'(1);
                    end
                end
            end
            // the matched `[` is stepped over, never re-evaluated
            SKIP_BACK: begin
                if (is_open && depth_one) begin
                    pc_nxt    = pc + ADDR_WIDTH'(1);
                    state_nxt = RUN;
                end else if (pc_first || (is_close && depth_full)) begin
                    state_nxt = ERROR;
                end else begin
                    pc_nxt = pc - ADDR_WIDTH'(1);
                    if (is_close)     depth_nxt = depth + DEPTH_WIDTH'(1);
                    else if (is_open) depth_nxt = depth - DEPTH_WIDTH'(1);
                end
            end
            HALT:    ;
            ERROR:   ;
            default: state_nxt = ERROR;
        endcase
    end

    assign bus.rom_address = pc;
    assign bus.insn        = bus.rom_data;
    assign bus.insn_valid  = insn_valid;
    assign bus.halted      = (state == HALT);
    assign bus.error       = (state == ERROR);

endmodule

// File: doc/bf_fetch_sequencer.md
# bf_fetch_sequencer

Program-counter sequencer for the asynchronous instruction ROM in the BF processor. It drives the ROM address and fetches one instruction per cycle. Data instructions go to the execution unit over a valid/ready handshake. The sequencer resolves `[` and `]` itself by scanning the ROM for the matching bracket, using a nesting-depth counter.

## Interface
Parameters:
- DATA_WIDTH, 4: instruction width; must match the ROM.
- ADDR_WIDTH, 8: ROM address width.
- DEPTH_WIDTH, 8: width of the bracket nesting counter.
- OP_LOOP_START, 4'h5: `[` opcode.
- OP_LOOP_END, 4'h6: `]` opcode.
- OP_HALT, 4'hF: halt opcode.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- rom_address, output, ADDR_WIDTH: equals the pc register (combinational from pc).
- rom_data, input, DATA_WIDTH: ROM output for rom_address, valid in the same cycle.
- insn, output, DATA_WIDTH: instruction offered to the execution unit.
- insn_valid, output, 1: insn is offered.
- insn_ready, input, 1: execution unit accepts insn this cycle.
- cell_zero, input, 1: current data cell == 0. Must reflect all instructions handshaked in earlier cycles.
- halted, output, 1: OP_HALT reached.
- error, output, 1: unmatched bracket or depth overflow.

## Operation
- Registers:
  - pc (ADDR_WIDTH)
  - depth (DEPTH_WIDTH)
  - state, one of RUN, SKIP_FWD, SKIP_BACK, HALT, ERROR
- insn = rom_data at all times. insn_valid = 1 only in RUN when rom_data is not a bracket and not OP_HALT.
- RUN:
  - Data opcode: hold pc until insn_valid & insn_ready, then pc <= pc+1.
  - OP_HALT: state <= HALT; pc holds.
  - `[` with cell_zero=0: pc <= pc+1.
  - `[` with cell_zero=1: depth <= 1, pc <= pc+1, state <= SKIP_FWD.
  - `]` with cell_zero=1: pc <= pc+1.
  - `]` with cell_zero=0: depth <= 1, pc <= pc-1, state <= SKIP_BACK.
- SKIP_FWD, one ROM word per cycle:
  - `[`: depth+1, pc+1.
  - `]` with depth==1: pc <= pc+1, state <= RUN. Execution resumes after the match.
  - `]` with depth>1: depth-1, pc+1.
  - Any other opcode, including OP_HALT: pc+1.
- SKIP_BACK, mirror of SKIP_FWD:
  - `]`: depth+1, pc-1.
  - `[` with depth==1: pc <= pc+1, state <= RUN. Execution resumes at the first instruction inside the loop; the `[` is not re-evaluated.
  - `[` with depth>1: depth-1, pc-1.
  - Any other opcode: pc-1.
- Boundaries:
  - SKIP_FWD needing to advance past address 2^ADDR_WIDTH-1: state <= ERROR. pc never wraps.
  - SKIP_BACK needing to step below address 0: state <= ERROR.
  - depth increment at all-ones: state <= ERROR.
  - RUN advancing pc+1 from the last address: state <= ERROR.
- HALT: halted=1, insn_valid=0, pc frozen. Left only by reset.
- ERROR: error=1, insn_valid=0, pc frozen. Left only by reset.
- insn_ready is ignored whenever insn_valid=0.

## Timing
- Reset, applied at any clock edge and in any state, including mid-scan:
  - pc=0, depth=0, state=RUN.
  - halted=0, error=0.
  - insn_valid follows the ROM word at address 0 in the next cycle.
- Data instruction: zero-latency offer. Throughput is 1 instruction/cycle while insn_ready=1.
- Bracket not taken: 1 cycle, no handshake.
- Forward skip over a match at distance d: 1 + d cycles. The first post-match instruction is offered in cycle d+1 after the `[` cycle.
- Backward jump from `]` to a `[` at distance d: 1 + d cycles. Then pc = (address of `[`) + 1.
- halted and error are registered; they assert the cycle after the causing edge.
- cell_zero is sampled only in RUN on bracket cycles. The execution unit must update it combinationally or within the handshake cycle.

## Test plan
- Straight-line program `+ + > HALT`, insn_ready tied 1: three handshakes in cycles 0-2, halted=1 from cycle 4, pc stays 3.
- Backpressure: insn_ready=0 for 3 cycles on address 0: pc holds 0, insn_valid stays 1, pc=1 the cycle after ready.
- `[` at address 2 with cell_zero=1, match `]` at 6 (nested pair at 3/5): pc reaches 7 after 5 cycles, and no insn_valid is asserted for addresses 3-6.
- `]` at address 8 with cell_zero=0, matching `[` at 1: pc reaches 2 in 8 cycles. Repeating with cell_zero=1 gives pc=9 in 1 cycle.
- Unmatched `[` with cell_zero=1 at the last address: error=1, pc frozen. Unmatched `]` at 0 with cell_zero=0: error=1.
- Reset asserted mid-SKIP_BACK: next cycle pc=0, state RUN, error=0, halted=0.
